// File: rtl/alu_exec_unit_pkg.sv
// Shared constants for the integer execution path: op encodings, tag/width
// constants and the op groupings that the decoder and RS also rely on.
package alu_exec_unit_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int OP_ENUM_W = 6;
    localparam int ROB_ID_W  = 4;

    localparam logic [ROB_ID_W-1:0] ROB_RESET = '1;

    typedef enum logic [OP_ENUM_W-1:0] {
        OP_NOP   = 6'd0,
        OP_ADD   = 6'd1,
        OP_SUB   = 6'd2,
        OP_AND   = 6'd3,
        OP_OR    = 6'd4,
        OP_XOR   = 6'd5,
        OP_SLL   = 6'd6,
        OP_SRL   = 6'd7,
        OP_SRA   = 6'd8,
        OP_SLT   = 6'd9,
        OP_SLTU  = 6'd10,
        OP_ADDI  = 6'd11,
        OP_ANDI  = 6'd12,
        OP_ORI   = 6'd13,
        OP_XORI  = 6'd14,
        OP_SLLI  = 6'd15,
        OP_SRLI  = 6'd16,
        OP_SRAI  = 6'd17,
        OP_SLTI  = 6'd18,
        OP_SLTIU = 6'd19,
        OP_LUI   = 6'd20,
        OP_AUIPC = 6'd21,
        OP_JAL   = 6'd22,
        OP_JALR  = 6'd23,
        OP_BEQ   = 6'd24,
        OP_BNE   = 6'd25,
        OP_BLT   = 6'd26,
        OP_BGE   = 6'd27,
        OP_BLTU  = 6'd28,
        OP_BGEU  = 6'd29
    } op_e;

    localparam logic [OP_ENUM_W-1:0] OP_ENUM_RESET = OP_NOP;

    function automatic logic is_branch(op_e op);
        return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    endfunction

    function automatic logic is_jump(op_e op);
        return op inside {OP_JAL, OP_JALR};
    endfunction

    // Register-immediate ALU forms: second operand comes from imm, not v2.
    function automatic logic uses_imm(op_e op);
        return op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI,
                          OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU};
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue bus from the reservation station and broadcast bus towards the CDB,
// bundled so the exec unit sees one port.
interface alu_exec_unit_if #(
    parameter int ROB_W = 4,
    parameter int OP_W  = 6
);
    logic [OP_W-1:0]  op_enum_in;
    logic [31:0]      v1_in;
    logic [31:0]      v2_in;
    logic [31:0]      imm_in;
    logic [31:0]      inst_pos_in;
    logic [ROB_W-1:0] rob_id_in;
    logic             busy_to_rs;

    logic             cdb_req_out;
    logic             cdb_grant_in;
    logic [ROB_W-1:0] cdb_rob_id_out;
    logic [31:0]      cdb_result_out;
    logic             cdb_br_taken_out;
    logic [31:0]      cdb_target_out;

    modport slave (
        input  op_enum_in, v1_in, v2_in, imm_in, inst_pos_in, rob_id_in,
        input  cdb_grant_in,
        output busy_to_rs,
        output cdb_req_out, cdb_rob_id_out, cdb_result_out,
        output cdb_br_taken_out, cdb_target_out
    );

    modport master (
        output op_enum_in, v1_in, v2_in, imm_in, inst_pos_in, rob_id_in,
        output cdb_grant_in,
        input  busy_to_rs,
        input  cdb_req_out, cdb_rob_id_out, cdb_result_out,
        input  cdb_br_taken_out, cdb_target_out
    );
endinterface

// File: rtl/alu_exec_unit_alu_compute.sv
// Single-cycle integer datapath: result, branch/jump outcome and redirect
// target for one op with ready operands.
module alu_compute
    import alu_exec_unit_pkg::*;
(
    input  logic [OP_ENUM_W-1:0] op,
    input  logic [DATA_W-1:0]    v1,
    input  logic [DATA_W-1:0]    v2,
    input  logic [DATA_W-1:0]    imm,
    input  logic [ADDR_W-1:0]    pc,
    output logic [DATA_W-1:0]    result,
    output logic                 taken,
    output logic [ADDR_W-1:0]    target
);

    op_e                      op_t;
    logic        [DATA_W-1:0] opb;
    logic signed [DATA_W-1:0] v1_s;
    logic signed [DATA_W-1:0] v2_s;
    logic signed [DATA_W-1:0] opb_s;
    logic        [4:0]        shamt;
    logic        [ADDR_W-1:0] pc_seq;
    logic        [ADDR_W-1:0] pc_off;
    logic        [ADDR_W-1:0] jalr_sum;

    assign op_t     = op_e'(op);
    assign opb      = uses_imm(op_t) ? imm : v2;
    assign v1_s     = $signed(v1);
    assign v2_s     = $signed(v2);
    assign opb_s    = $signed(opb);
    assign shamt    = opb[4:0];
    assign pc_seq   = pc + 32'd4;
    assign pc_off   = pc + imm;
    assign jalr_sum = v1 + imm;

    always_comb begin
        result = '0;
        taken  = 1'b0;
        target = pc_seq;
        case (op_t)
            OP_ADD,  OP_ADDI:  result = v1 + opb;
            OP_SUB:            result = v1 - v2;
            OP_AND,  OP_ANDI:  result = v1 & opb;
            OP_OR,   OP_ORI:   result = v1 | opb;
            OP_XOR,  OP_XORI:  result = v1 ^ opb;
            OP_SLL,  OP_SLLI:  result = v1 << shamt;
            OP_SRL,  OP_SRLI:  result = v1 >> shamt;
            OP_SRA,  OP_SRAI:  result = $unsigned(v1_s >>> shamt);
            OP_SLT,  OP_SLTI:  result = {{(DATA_W-1){1'b0}}, (v1_s < opb_s)};
            OP_SLTU, OP_SLTIU: result = {{(DATA_W-1){1'b0}}, (v1 < opb)};
            OP_LUI:            result = imm;
            OP_AUIPC:          result = pc_off;
            OP_JAL: begin
                result = pc_seq;
                taken  = 1'b1;
                target = pc_off;
            end
            OP_JALR: begin
                result = pc_seq;
                taken  = 1'b1;
                target = jalr_sum & {{(ADDR_W-1){1'b1}}, 1'b0};
            end
            OP_BEQ:            taken = (v1 == v2);
            OP_BNE:            taken = (v1 != v2);
            OP_BLT:            taken = (v1_s < v2_s);
            OP_BGE:            taken = (v1_s >= v2_s);
            OP_BLTU:           taken = (v1 < v2);
            OP_BGEU:           taken = (v1 >= v2);
            default:           ;
        endcase
        if (is_branch(op_t) && taken) begin
            target = pc_off;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Integer execute stage: computes one issued op per cycle and parks results
// in an in-order completion queue until the CDB arbiter grants a broadcast.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ROB_W = ROB_ID_W,
    parameter int OP_W  = OP_ENUM_W
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             rollback_in,
    alu_exec_unit_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic [ROB_W-1:0]  q_rob [DEPTH];
    logic [DATA_W-1:0] q_res [DEPTH];
    logic              q_tkn [DEPTH];
    logic [ADDR_W-1:0] q_tgt [DEPTH];

    logic [DATA_W-1:0] res_p0;
    logic              tkn_p0;
    logic [ADDR_W-1:0] tgt_p0;
    logic              vld_p0;

    logic empty;
    logic full;
    logic pop;
    logic push;

    alu_compute u_alu_compute (
        .op     (OP_ENUM_W'(bus.op_enum_in)),
        .v1     (bus.v1_in),
        .v2     (bus.v2_in),
        .imm    (bus.imm_in),
        .pc     (bus.inst_pos_in),
        .result (res_p0),
        .taken  (tkn_p0),
        .target (tgt_p0)
    );

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    // A flush cycle swallows both the issue and any grant.
    assign vld_p0 = rdy_in && !rollback_in && (bus.op_enum_in != OP_W'(OP_ENUM_RESET));
    assign pop    = !empty && bus.cdb_grant_in && rdy_in && !rollback_in;
    // Pop frees the head slot on the same edge, so a full queue can still accept.
    assign push   = vld_p0 && (!full || pop);

    // ---- stage p0 -> completion queue ----
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (rollback_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (pop)  head <= head + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            q_rob[tail] <= bus.rob_id_in;
            q_res[tail] <= res_p0;
            q_tkn[tail] <= tkn_p0;
            q_tgt[tail] <= tgt_p0;
        end
    end

    // ---- queue head -> CDB ----
    always_comb begin
        bus.cdb_req_out      = 1'b0;
        bus.cdb_rob_id_out   = {ROB_W{1'b1}};
        bus.cdb_result_out   = '0;
        bus.cdb_br_taken_out = 1'b0;
        bus.cdb_target_out   = '0;
        if (!empty) begin
            bus.cdb_req_out      = 1'b1;
            bus.cdb_rob_id_out   = q_rob[head];
            bus.cdb_result_out   = q_res[head];
            bus.cdb_br_taken_out = q_tkn[head];
            bus.cdb_target_out   = q_tgt[head];
        end
    end

    // One slot of slack absorbs the op the RS has already launched.
    assign bus.busy_to_rs = (count >= CNT_W'(DEPTH - 1));

    overflow_dropped: assert property (
        @(posedge clk_in) disable iff (!rst_n_in)
        !(vld_p0 && full && !pop)
    );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: datapath vectors, ordering, back-pressure,
// full-queue push/pop, flush, freeze and asynchronous reset.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    logic clk_in;
    logic rst_n_in;
    logic rdy_in;
    logic rollback_in;

    int errors = 0;
    int checks = 0;
    int rob_seq = 0;

    alu_exec_unit_if #(.ROB_W(4), .OP_W(6)) bus ();

    alu_exec_unit #(.DEPTH(4), .ROB_W(4), .OP_W(6)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rdy_in      (rdy_in),
        .rollback_in (rollback_in),
        .bus         (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
        bus.op_enum_in  = op;
        bus.v1_in       = v1;
        bus.v2_in       = v2;
        bus.imm_in      = imm;
        bus.inst_pos_in = pc;
        bus.rob_id_in   = rob;
    endtask

    task automatic head(input string tag, input logic [3:0] rob, input logic [31:0] res,
                        input logic tkn, input logic [31:0] tgt);
        chk({tag, ".req"}, 32'(bus.cdb_req_out), 32'd1);
        chk({tag, ".rob"}, 32'(bus.cdb_rob_id_out), 32'(rob));
        chk({tag, ".res"}, bus.cdb_result_out, res);
        chk({tag, ".tkn"}, 32'(bus.cdb_br_taken_out), 32'(tkn));
        chk({tag, ".tgt"}, bus.cdb_target_out, tgt);
    endtask

    task automatic idle_out(input string tag);
        chk({tag, ".req"}, 32'(bus.cdb_req_out), 32'd0);
        chk({tag, ".rob"}, 32'(bus.cdb_rob_id_out), 32'hF);
        chk({tag, ".res"}, bus.cdb_result_out, 32'd0);
        chk({tag, ".tkn"}, 32'(bus.cdb_br_taken_out), 32'd0);
        chk({tag, ".tgt"}, bus.cdb_target_out, 32'd0);
    endtask

    // Grant held high: each op is pushed, shows at the head, and is popped next edge.
    task automatic vec(input string tag, input logic [5:0] op, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] imm, input logic [31:0] pc,
                       input logic [31:0] res, input logic tkn, input logic [31:0] tgt);
        logic [3:0] rob;
        rob = 4'(rob_seq % 15);
        rob_seq++;
        issue(op, v1, v2, imm, pc, rob);
        tick();
        head(tag, rob, res, tkn, tgt);
    endtask

    initial begin
        rst_n_in = 1'b0;
        rdy_in = 1'b1;
        rollback_in = 1'b0;
        bus.cdb_grant_in = 1'b0;
        issue(6'd0, 0, 0, 0, 0, 0);
        #1;
        idle_out("reset");
        chk("reset.busy", 32'(bus.busy_to_rs), 32'd0);
        #11 rst_n_in = 1'b1;
        tick();

        // ADD, one-cycle latency, popped by a held grant
        bus.cdb_grant_in = 1'b1;
        issue(OP_ADD, 5, 7, 0, 0, 4'd3);
        tick();
        bus.op_enum_in = 6'd0;
        head("add", 4'd3, 32'd12, 1'b0, 32'd4);
        tick();
        chk("add.drain.req", 32'(bus.cdb_req_out), 32'd0);

        // signed vs unsigned branch on the same operands
        bus.cdb_grant_in = 1'b0;
        issue(OP_BLT, 32'hFFFFFFFF, 1, 32'h20, 32'h100, 4'd5);
        tick();
        bus.op_enum_in = 6'd0;
        head("blt", 4'd5, 32'd0, 1'b1, 32'h120);
        bus.cdb_grant_in = 1'b1;
        issue(OP_BLTU, 32'hFFFFFFFF, 1, 32'h20, 32'h100, 4'd6);
        tick();
        bus.op_enum_in = 6'd0;
        head("bltu", 4'd6, 32'd0, 1'b0, 32'h104);
        tick();
        chk("bltu.drain.req", 32'(bus.cdb_req_out), 32'd0);

        // JALR clears bit 0 of the target
        bus.cdb_grant_in = 1'b0;
        issue(OP_JALR, 32'h203, 0, 4, 32'h40, 4'd7);
        tick();
        bus.op_enum_in = 6'd0;
        head("jalr", 4'd7, 32'h44, 1'b1, 32'h206);
        bus.cdb_grant_in = 1'b1;
        tick();
        chk("jalr.drain.req", 32'(bus.cdb_req_out), 32'd0);

        // datapath sweep, grant high throughout
        vec("sub",   OP_SUB,   5, 7, 0, 32'h300, 32'hFFFFFFFE, 1'b0, 32'h304);
        vec("and",   OP_AND,   32'hF0F0, 32'hFF00, 0, 32'h300, 32'hF000, 1'b0, 32'h304);
        vec("or",    OP_OR,    32'hF0F0, 32'hFF00, 0, 32'h300, 32'hFFF0, 1'b0, 32'h304);
        vec("xor",   OP_XOR,   32'hF0F0, 32'hFF00, 0, 32'h300, 32'h0FF0, 1'b0, 32'h304);
        vec("sll",   OP_SLL,   1, 33, 0, 32'h300, 32'd2, 1'b0, 32'h304);
        vec("srl",   OP_SRL,   32'h80000000, 4, 0, 32'h300, 32'h08000000, 1'b0, 32'h304);
        vec("sra",   OP_SRA,   32'h80000000, 4, 0, 32'h300, 32'hF8000000, 1'b0, 32'h304);
        vec("slt",   OP_SLT,   32'hFFFFFFFF, 1, 0, 32'h300, 32'd1, 1'b0, 32'h304);
        vec("sltu",  OP_SLTU,  32'hFFFFFFFF, 1, 0, 32'h300, 32'd0, 1'b0, 32'h304);
        vec("addi",  OP_ADDI,  10, 99, 32'hFFFFFFFF, 32'h300, 32'd9, 1'b0, 32'h304);
        vec("srai",  OP_SRAI,  32'h80000000, 0, 32'h24, 32'h300, 32'hF8000000, 1'b0, 32'h304);
        vec("slti",  OP_SLTI,  32'hFFFFFFFE, 0, 32'hFFFFFFFF, 32'h300, 32'd1, 1'b0, 32'h304);
        vec("sltiu", OP_SLTIU, 1, 0, 32'hFFFFFFFF, 32'h300, 32'd1, 1'b0, 32'h304);
        vec("xori",  OP_XORI,  32'hFF, 0, 32'h0F, 32'h300, 32'hF0, 1'b0, 32'h304);
        vec("lui",   OP_LUI,   7, 7, 32'h12345000, 32'h300, 32'h12345000, 1'b0, 32'h304);
        vec("auipc", OP_AUIPC, 0, 0, 32'h10, 32'h1000, 32'h1010, 1'b0, 32'h1004);
        vec("jal",   OP_JAL,   0, 0, 32'hFFFFFFF8, 32'h200, 32'h204, 1'b1, 32'h1F8);
        vec("beq",   OP_BEQ,   3, 3, 32'h10, 32'h300, 32'd0, 1'b1, 32'h310);
        vec("bne",   OP_BNE,   3, 3, 32'h10, 32'h300, 32'd0, 1'b0, 32'h304);
        vec("bge",   OP_BGE,   32'hFFFFFFFF, 1, 32'h10, 32'h300, 32'd0, 1'b0, 32'h304);
        vec("bgeu",  OP_BGEU,  32'hFFFFFFFF, 1, 32'h10, 32'h300, 32'd0, 1'b1, 32'h310);
        vec("unk",   6'd63,    5, 7, 32'h10, 32'h300, 32'd0, 1'b0, 32'h304);
        bus.op_enum_in = 6'd0;
        tick();
        chk("sweep.drain.req", 32'(bus.cdb_req_out), 32'd0);

        // fill to four entries with grant low; busy from the third push
        bus.cdb_grant_in = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            issue(OP_ADDI, 10, 0, 32'(k), 0, 4'(k));
            tick();
            chk($sformatf("fill%0d.busy", k), 32'(bus.busy_to_rs), (k >= 3) ? 32'd1 : 32'd0);
        end
        bus.op_enum_in = 6'd0;
        head("full.hold", 4'd1, 32'd11, 1'b0, 32'd4);
        tick();
        head("full.hold2", 4'd1, 32'd11, 1'b0, 32'd4);
        chk("full.hold2.busy", 32'(bus.busy_to_rs), 32'd1);

        // push into a full queue while the head is granted
        bus.cdb_grant_in = 1'b1;
        issue(OP_ADDI, 10, 0, 5, 0, 4'd5);
        tick();
        bus.op_enum_in = 6'd0;
        head("fullpp.h2", 4'd2, 32'd12, 1'b0, 32'd4);
        chk("fullpp.h2.busy", 32'(bus.busy_to_rs), 32'd1);
        tick();
        head("drain.h3", 4'd3, 32'd13, 1'b0, 32'd4);
        chk("drain.h3.busy", 32'(bus.busy_to_rs), 32'd1);
        tick();
        head("drain.h4", 4'd4, 32'd14, 1'b0, 32'd4);
        chk("drain.h4.busy", 32'(bus.busy_to_rs), 32'd0);
        tick();
        head("drain.h5", 4'd5, 32'd15, 1'b0, 32'd4);
        tick();
        idle_out("drain.empty");

        // rollback with three queued plus a same-cycle issue and grant
        bus.cdb_grant_in = 1'b0;
        for (int k = 8; k <= 10; k++) begin
            issue(OP_ADD, 32'(k), 0, 0, 0, 4'(k));
            tick();
        end
        head("pre.flush", 4'd8, 32'd8, 1'b0, 32'd4);
        chk("pre.flush.busy", 32'(bus.busy_to_rs), 32'd1);
        issue(OP_ADD, 1, 1, 0, 0, 4'd11);
        rollback_in = 1'b1;
        bus.cdb_grant_in = 1'b1;
        tick();
        rollback_in = 1'b0;
        bus.op_enum_in = 6'd0;
        bus.cdb_grant_in = 1'b0;
        idle_out("flush");
        chk("flush.busy", 32'(bus.busy_to_rs), 32'd0);

        issue(OP_ADD, 1, 1, 0, 0, 4'd2);
        tick();
        issue(OP_SUB, 9, 4, 0, 32'h500, 4'd3);
        tick();
        bus.op_enum_in = 6'd0;
        head("postflush", 4'd2, 32'd2, 1'b0, 32'd4);

        // rdy low freezes everything despite issue and grant
        rdy_in = 1'b0;
        bus.cdb_grant_in = 1'b1;
        issue(OP_ADD, 3, 3, 0, 0, 4'd12);
        for (int c = 0; c < 5; c++) begin
            tick();
            head($sformatf("freeze%0d", c), 4'd2, 32'd2, 1'b0, 32'd4);
            chk($sformatf("freeze%0d.busy", c), 32'(bus.busy_to_rs), 32'd0);
        end
        rdy_in = 1'b1;
        bus.op_enum_in = 6'd0;
        tick();
        head("thaw", 4'd3, 32'd5, 1'b0, 32'h504);

        // asynchronous reset with a pending grant and rdy low
        rdy_in = 1'b0;
        #3 rst_n_in = 1'b0;
        #1;
        idle_out("async.reset");
        chk("async.reset.busy", 32'(bus.busy_to_rs), 32'd0);
        #2 rst_n_in = 1'b1;
        rdy_in = 1'b1;
        bus.cdb_grant_in = 1'b0;
        tick();
        chk("after.reset.req", 32'(bus.cdb_req_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
